// File: rtl/seven_pkg.sv
// Shared widths, limits and FSM state encoding for the binary-to-BCD converter.
package seven_pkg;

    localparam int BIN_W      = 14;
    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int MAX_VALUE  = 9999;
    localparam int ITERATIONS = 14;
    localparam int CNT_W      = $clog2(ITERATIONS);
    localparam int BCD_W      = DIGIT_W * NUM_DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more.
module bcd_add3
    import seven_pkg::*;
(
    input  logic [DIGIT_W-1:0] value,
    output logic [DIGIT_W-1:0] corrected
);

    assign corrected = (value >= 4'd5) ? value + 4'd3 : value;

endmodule

// File: rtl/binary_to_bcd.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-and-add-3).
// Define BCD_SATURATE_EN to show 9999 on overflow instead of value mod 10000.
module binary_to_bcd
    import seven_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [BIN_W-1:0]   binary,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [DIGIT_W-1:0] digit_1,
    output logic [DIGIT_W-1:0] digit_2,
    output logic [DIGIT_W-1:0] digit_3,
    output logic [DIGIT_W-1:0] digit_4
);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [BIN_W-1:0]   shreg_q;
    logic [BCD_W-1:0]   scratch_q;
    logic               ovf_cap_q;
    logic [BCD_W-1:0]   scratch_adj;
    logic [BCD_W-1:0]   scratch_nxt;
    logic               accept;
    logic               last;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .value     (scratch_q[i*DIGIT_W +: DIGIT_W]),
            .corrected (scratch_adj[i*DIGIT_W +: DIGIT_W])
        );
    end

    // Ten-thousands carry falls off the top of the scratch register here.
    assign scratch_nxt = {scratch_adj[BCD_W-2:0], shreg_q[BIN_W-1]};

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            scratch_q <= '0;
            ovf_cap_q <= 1'b0;
            overflow  <= 1'b0;
            digit_1   <= '0;
            digit_2   <= '0;
            digit_3   <= '0;
            digit_4   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                shreg_q   <= binary;
                scratch_q <= '0;
                cnt_q     <= CNT_W'(ITERATIONS - 1);
                ovf_cap_q <= (int'(binary) > MAX_VALUE);
            end else if (state_q == SHIFT) begin
                shreg_q   <= shreg_q << 1;
                scratch_q <= scratch_nxt;
                if (!last) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
            if (last) begin
                overflow <= ovf_cap_q;
`ifdef BCD_SATURATE_EN
                if (ovf_cap_q) begin
                    digit_1 <= 4'd9;
                    digit_2 <= 4'd9;
                    digit_3 <= 4'd9;
                    digit_4 <= 4'd9;
                end else begin
                    digit_1 <= scratch_nxt[15:12];
                    digit_2 <= scratch_nxt[11:8];
                    digit_3 <= scratch_nxt[7:4];
                    digit_4 <= scratch_nxt[3:0];
                end
`else
                digit_1 <= scratch_nxt[15:12];
                digit_2 <= scratch_nxt[11:8];
                digit_3 <= scratch_nxt[7:4];
                digit_4 <= scratch_nxt[3:0];
`endif
            end
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_binary_to_bcd.sv
// Self-checking bench for binary_to_bcd with an arithmetic reference model.
// Honours BCD_SATURATE_EN the same way as the design.
module tb_binary_to_bcd;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] binary;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [3:0]  digit_1;
    logic [3:0]  digit_2;
    logic [3:0]  digit_3;
    logic [3:0]  digit_4;

    int errors = 0;
    int checks = 0;

    binary_to_bcd dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .binary   (binary),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .digit_1  (digit_1),
        .digit_2  (digit_2),
        .digit_3  (digit_3),
        .digit_4  (digit_4)
    );

    always #5 clock = ~clock;

    function automatic logic [16:0] model(input int v);
        int m;
        bit ovf;
        ovf = (v > 9999);
`ifdef BCD_SATURATE_EN
        m = ovf ? 9999 : v;
`else
        m = v % 10000;
`endif
        return {ovf, 4'(m / 1000), 4'((m / 100) % 10),
                4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic [16:0] observed();
        return {overflow, digit_1, digit_2, digit_3, digit_4};
    endfunction

    // Issue a one-cycle start; return at the negedge where done is seen.
    task automatic convert(input int v, output int lat, output int bc);
        @(negedge clock);
        start  = 1'b1;
        binary = 14'(v);
        @(negedge clock);
        start = 1'b0;
        lat = 0;
        bc  = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        binary = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, done, observed()} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state got=%h want=0", {busy, done, observed()});
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic();
        int lat, bc;
        convert(1234, lat, bc);
        checks++;
        if (lat !== 14) begin
            errors++;
            $display("FAIL basic_latency got=%0d want=14", lat);
        end
        checks++;
        if (bc !== 14) begin
            errors++;
            $display("FAIL basic_busy_cycles got=%0d want=14", bc);
        end
        checks++;
        if (observed() !== model(1234)) begin
            errors++;
            $display("FAIL basic_1234 got=%h want=%h", observed(), model(1234));
        end
        @(negedge clock);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL done_pulse got=%b want=00", {busy, done});
        end
    endtask

    task automatic test_extremes();
        int lat, bc;
        int vals[3] = '{0, 9999, 12345};
        foreach (vals[i]) begin
            convert(vals[i], lat, bc);
            checks++;
            if (lat !== 14 || observed() !== model(vals[i])) begin
                errors++;
                $display("FAIL extreme_%0d got=%h lat=%0d want=%h lat=14",
                         vals[i], observed(), lat, model(vals[i]));
            end
        end
    endtask

    task automatic test_random();
        int lat, bc, v;
        for (int i = 0; i < 24; i++) begin
            v = (i % 3 == 0) ? int'($urandom_range(10000, 16383))
                             : int'($urandom_range(0, 9999));
            convert(v, lat, bc);
            checks++;
            if (lat !== 14 || observed() !== model(v)) begin
                errors++;
                $display("FAIL random_%0d got=%h lat=%0d want=%h lat=14",
                         v, observed(), lat, model(v));
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat, bc;
        logic [16:0] prev;
        convert(777, lat, bc);
        prev = observed();
        @(negedge clock);
        start  = 1'b1;
        binary = 14'd300;
        @(negedge clock);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            if (lat == 5) begin
                start  = 1'b1;
                binary = 14'd9000;
            end else begin
                start = 1'b0;
            end
            if (lat == 7) begin
                checks++;
                if (observed() !== prev) begin
                    errors++;
                    $display("FAIL hold_during_busy got=%h want=%h",
                             observed(), prev);
                end
            end
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        checks++;
        if (lat !== 14 || observed() !== model(300)) begin
            errors++;
            $display("FAIL busy_ignore got=%h lat=%0d want=%h lat=14",
                     observed(), lat, model(300));
        end
        @(negedge clock);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL ignored_not_queued got=%b want=00", {busy, done});
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clock);
        start  = 1'b1;
        binary = 14'd42;
        @(negedge clock);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        checks++;
        if (lat !== 14 || observed() !== model(42)) begin
            errors++;
            $display("FAIL b2b_first got=%h lat=%0d want=%h lat=14",
                     observed(), lat, model(42));
        end
        binary = 14'd507;
        @(negedge clock);
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_accept got=%b want=10", {busy, done});
        end
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        checks++;
        if (lat !== 14 || observed() !== model(507)) begin
            errors++;
            $display("FAIL b2b_second got=%h lat=%0d want=%h lat=14",
                     observed(), lat, model(507));
        end
        @(negedge clock);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle got=%b want=00", {busy, done});
        end
    endtask

    task automatic test_mid_reset();
        int lat, bc, seen;
        convert(16000, lat, bc);
        @(negedge clock);
        start  = 1'b1;
        binary = 14'd8888;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, observed()} !== 19'd0) begin
            errors++;
            $display("FAIL mid_reset_clear got=%h want=0",
                     {busy, done, observed()});
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clock);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL mid_reset_no_done got=%0d want=0", seen);
        end
        convert(8888, lat, bc);
        checks++;
        if (lat !== 14 || observed() !== model(8888)) begin
            errors++;
            $display("FAIL after_reset_8888 got=%h lat=%0d want=%h lat=14",
                     observed(), lat, model(8888));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
